// File: rtl/bf2_pair_feeder_pkg.sv
// -----------------------------------------------------------------------------
// bf2_pair_feeder_pkg
// Shared FFT package for the radix-2 butterfly input feeder.
// Holds the feeder state enum and the default sample width / half-block length
// used as parameter defaults by the interface, buffer and top.
// Optional feature macro used elsewhere in this slice: BF2_FEED_ERR_EN.
// -----------------------------------------------------------------------------
package bf2_pair_feeder_pkg;

  // Default width of each real / quadrature component
  localparam int DEF_WIDTH  = 16;

  // Default half-block length (power of two, >= 2)
  localparam int DEF_N_HALF = 8;

  // IDLE: waiting for a start-of-block sample
  // FILL: storing the first half of the block
  // PAIR: pairing stored first-half samples with live second-half samples
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAIR = 2'd2
  } feed_state_t;

endpackage

// File: rtl/bf2_pair_feeder_if.sv
// -----------------------------------------------------------------------------
// bf2_pair_feeder_if
// Bundles the serial sample input and the butterfly pair output of the feeder.
//   din_R, din_Q     serial complex sample (signed, WIDTH bits each)
//   din_valid        sample accepted on any cycle where high
//   din_sof          first sample of a block (qualified by din_valid)
//   dout_R_1/Q_1     stored first-half sample x[n]
//   dout_R_2/Q_2     live second-half sample x[n+N_HALF]
//   pair_en          outputs hold a valid pair
//   pair_last        final pair of a block
//   sync_err         sticky restart flag, present only with BF2_FEED_ERR_EN
// Modports: master = sample source / pair sink, slave = the feeder itself.
// -----------------------------------------------------------------------------
interface bf2_pair_feeder_if
  import bf2_pair_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic signed [WIDTH-1:0] din_R;
  logic signed [WIDTH-1:0] din_Q;
  logic                    din_valid;
  logic                    din_sof;
  logic signed [WIDTH-1:0] dout_R_1;
  logic signed [WIDTH-1:0] dout_Q_1;
  logic signed [WIDTH-1:0] dout_R_2;
  logic signed [WIDTH-1:0] dout_Q_2;
  logic                    pair_en;
  logic                    pair_last;
`ifdef BF2_FEED_ERR_EN
  logic                    sync_err;
`endif

  modport master (
    output din_R, din_Q, din_valid, din_sof,
    input  dout_R_1, dout_Q_1, dout_R_2, dout_Q_2, pair_en, pair_last
`ifdef BF2_FEED_ERR_EN
    , input sync_err
`endif
  );

  modport slave (
    input  din_R, din_Q, din_valid, din_sof,
    output dout_R_1, dout_Q_1, dout_R_2, dout_Q_2, pair_en, pair_last
`ifdef BF2_FEED_ERR_EN
    , output sync_err
`endif
  );

endinterface

// File: rtl/bf2_feed_buf.sv
// -----------------------------------------------------------------------------
// bf2_feed_buf
// First-half sample store for the butterfly feeder: N_HALF words of
// {R, Q} (2*WIDTH bits). One synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
//   clk      clock, write on rising edge
//   wr_en    write enable
//   wr_addr  write index
//   wr_data  packed {R, Q} sample
//   rd_addr  read index
//   rd_data  packed {R, Q} sample at rd_addr (combinational)
// -----------------------------------------------------------------------------
module bf2_feed_buf
  import bf2_pair_feeder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N_HALF = DEF_N_HALF,
  localparam int AW    = $clog2(N_HALF)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [2*WIDTH-1:0]   wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [2*WIDTH-1:0]   rd_data
);

  logic [2*WIDTH-1:0] mem [N_HALF];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bf2_pair_feeder.sv
// -----------------------------------------------------------------------------
// bf2_pair_feeder
// Turns a serial complex sample stream into radix-2 butterfly operand pairs.
// The first N_HALF samples of a block are stored; each following sample is
// presented together with its stored partner x[n] one cycle after acceptance.
//   clk    single clock, rising edge
//   rstn   asynchronous active-low reset
//   bus    bf2_pair_feeder_if slave modport (samples in, pairs out)
// Optional feature: define BF2_FEED_ERR_EN to add the sticky bus.sync_err flag,
// set on the cycle after a start-of-block arrives in the middle of a block.
// -----------------------------------------------------------------------------
module bf2_pair_feeder
  import bf2_pair_feeder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N_HALF = DEF_N_HALF
) (
  input  logic          clk,
  input  logic          rstn,
  bf2_pair_feeder_if.slave bus
);

  localparam int               CW   = $clog2(N_HALF);
  localparam logic [CW-1:0]    LAST = CW'(N_HALF - 1);

  feed_state_t        state, next_state;
  logic [CW-1:0]      cnt, next_cnt;
  logic               wr_en;
  logic [CW-1:0]      wr_addr;
  logic               emit;
  logic               emit_last;
  logic               restart;
  logic [2*WIDTH-1:0] rd_data;

  bf2_feed_buf #(
    .WIDTH  (WIDTH),
    .N_HALF (N_HALF)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({bus.din_R, bus.din_Q}),
    .rd_addr (cnt),
    .rd_data (rd_data)
  );

  // State and index register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic. A valid sof always wins and restarts the block at
  // index 0, whatever state we are in; it never produces a pair.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    wr_en      = 1'b0;
    wr_addr    = cnt;
    emit       = 1'b0;
    emit_last  = 1'b0;
    restart    = 1'b0;
    if (bus.din_valid) begin
      if (bus.din_sof) begin
        restart    = (state != IDLE);
        wr_en      = 1'b1;
        wr_addr    = '0;
        next_cnt   = CW'(1);
        next_state = FILL;
      end else begin
        unique case (state)
          FILL: begin
            wr_en = 1'b1;
            if (cnt == LAST) begin
              next_cnt   = '0;
              next_state = PAIR;
            end else begin
              next_cnt = cnt + CW'(1);
            end
          end
          PAIR: begin
            emit = 1'b1;
            if (cnt == LAST) begin
              emit_last  = 1'b1;
              next_cnt   = '0;
              next_state = IDLE;
            end else begin
              next_cnt = cnt + CW'(1);
            end
          end
          default: begin
            next_state = IDLE;
          end
        endcase
      end
    end
  end

  // Pair output register: data only moves when a pair is emitted, so the
  // outputs hold their last pair while pair_en is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.dout_R_1  <= '0;
      bus.dout_Q_1  <= '0;
      bus.dout_R_2  <= '0;
      bus.dout_Q_2  <= '0;
      bus.pair_en   <= 1'b0;
      bus.pair_last <= 1'b0;
    end else begin
      bus.pair_en   <= emit;
      bus.pair_last <= emit_last;
      if (emit) begin
        bus.dout_R_1 <= rd_data[2*WIDTH-1:WIDTH];
        bus.dout_Q_1 <= rd_data[WIDTH-1:0];
        bus.dout_R_2 <= bus.din_R;
        bus.dout_Q_2 <= bus.din_Q;
      end
    end
  end

`ifdef BF2_FEED_ERR_EN
  // Sticky restart flag, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.sync_err <= 1'b0;
    end else if (restart) begin
      bus.sync_err <= 1'b1;
    end
  end
`else
  logic unused_restart;
  assign unused_restart = restart;
`endif

endmodule
